// File: rtl/serial_input.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
// Module      : serial_input
// Description : 8N1 UART receiver plus ASCII-hex message assembler. Builds a
//               value (most significant digit first) and a digit count, and
//               presents them with a finish level that is held until the
//               downstream transmit stage returns its handshake.
// Revision    : 1.0 - initial release
// ============================================================================
module serial_input #(
  parameter int OVERSAMPLE = 16,
  parameter int MAX_DIGITS = 16
) (
  input  logic                             IN_clk,
  input  logic                             IN_rst_n,
  input  logic                             IN_rx,
  input  logic                             IN_shake_hand,
  output logic [4*MAX_DIGITS-1:0]          OUT_value,
  output logic [$clog2(MAX_DIGITS+1)-1:0]  OUT_number,
  output logic                             OUT_finish,
  output logic                             OUT_err
);

  localparam int C_VAL_W = 4 * MAX_DIGITS;
  localparam int C_NUM_W = $clog2(MAX_DIGITS + 1);
  localparam int C_TCK_W = $clog2(OVERSAMPLE);

  localparam logic [C_TCK_W-1:0] C_TICK_MID  = C_TCK_W'(OVERSAMPLE / 2 - 1);
  localparam logic [C_TCK_W-1:0] C_TICK_LAST = C_TCK_W'(OVERSAMPLE - 1);
  localparam logic [C_NUM_W-1:0] C_CNT_FULL  = C_NUM_W'(MAX_DIGITS);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_START = 2'd1,
    S_DATA  = 2'd2,
    S_STOP  = 2'd3
  } rx_state_t;

  // Receiver state
  logic               sync1_q;
  logic               sync2_q;      // synchronised RX line; all decisions use this
  rx_state_t          state_q;
  logic [C_TCK_W-1:0] tick_q;
  logic [2:0]         bit_q;
  logic [7:0]         shift_q;      // holds the received byte while strobe_q is high
  logic               stop_wait_q;  // bad stop bit seen, waiting for line to go idle
  logic               strobe_q;
  logic               ferr_q;

  // Assembler state
  logic [C_VAL_W-1:0] acc_q;
  logic [C_NUM_W-1:0] cnt_q;
  logic               discard_q;
  logic [C_VAL_W-1:0] value_q;
  logic [C_NUM_W-1:0] number_q;
  logic               finish_q;
  logic               err_q;

  // Character classification
  logic               w_is_digit;
  logic               w_is_term;
  logic [3:0]         w_nibble;

  // Two-flop synchroniser; idles high so reset never looks like a start bit
  always_ff @(posedge IN_clk or negedge IN_rst_n) begin
    if (!IN_rst_n) begin
      sync1_q <= 1'b1;
      sync2_q <= 1'b1;
    end else begin
      sync1_q <= IN_rx;
      sync2_q <= sync1_q;
    end
  end

  // Frame receiver: mid-bit sampling, one-cycle byte strobe or framing-error pulse
  always_ff @(posedge IN_clk or negedge IN_rst_n) begin
    if (!IN_rst_n) begin
      state_q     <= S_IDLE;
      tick_q      <= '0;
      bit_q       <= '0;
      shift_q     <= '0;
      stop_wait_q <= 1'b0;
      strobe_q    <= 1'b0;
      ferr_q      <= 1'b0;
    end else begin
      strobe_q <= 1'b0;
      ferr_q   <= 1'b0;
      case (state_q)
        S_IDLE: begin
          if (!sync2_q) begin
            state_q <= S_START;
            tick_q  <= '0;
          end
        end
        S_START: begin
          if (tick_q == C_TICK_MID) begin
            if (sync2_q) begin
              // Line went back high before mid start bit: treat as a glitch
              state_q <= S_IDLE;
            end else begin
              state_q <= S_DATA;
              tick_q  <= '0;
              bit_q   <= '0;
            end
          end else begin
            tick_q <= tick_q + C_TCK_W'(1);
          end
        end
        S_DATA: begin
          if (tick_q == C_TICK_LAST) begin
            tick_q  <= '0;
            shift_q <= {sync2_q, shift_q[7:1]};
            bit_q   <= bit_q + 3'd1;
            if (bit_q == 3'd7) begin
              state_q <= S_STOP;
            end
          end else begin
            tick_q <= tick_q + C_TCK_W'(1);
          end
        end
        S_STOP: begin
          if (stop_wait_q) begin
            if (sync2_q) begin
              stop_wait_q <= 1'b0;
              state_q     <= S_IDLE;
            end
          end else if (tick_q == C_TICK_LAST) begin
            tick_q <= '0;
            if (sync2_q) begin
              strobe_q <= 1'b1;
              state_q  <= S_IDLE;
            end else begin
              ferr_q      <= 1'b1;
              stop_wait_q <= 1'b1;
            end
          end else begin
            tick_q <= tick_q + C_TCK_W'(1);
          end
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  // Classify the received byte as hex digit, terminator or other
  always_comb begin
    w_is_digit = 1'b0;
    w_nibble   = 4'd0;
    w_is_term  = (shift_q == 8'h0D) || (shift_q == 8'h0A);
    if (shift_q >= 8'h30 && shift_q <= 8'h39) begin
      w_is_digit = 1'b1;
      w_nibble   = shift_q[3:0];
    end else if ((shift_q >= 8'h41 && shift_q <= 8'h46) ||
                 (shift_q >= 8'h61 && shift_q <= 8'h66)) begin
      // 'A'..'F' and 'a'..'f' have low nibble 1..6
      w_is_digit = 1'b1;
      w_nibble   = shift_q[3:0] + 4'd9;
    end
  end

  // Message assembler, output register and handshake
  always_ff @(posedge IN_clk or negedge IN_rst_n) begin
    if (!IN_rst_n) begin
      acc_q     <= '0;
      cnt_q     <= '0;
      discard_q <= 1'b0;
      value_q   <= '0;
      number_q  <= '0;
      finish_q  <= 1'b0;
      err_q     <= 1'b0;
    end else begin
      err_q <= 1'b0;
      if (finish_q && IN_shake_hand) begin
        finish_q <= 1'b0;
      end
      if (ferr_q) begin
        err_q     <= 1'b1;
        discard_q <= 1'b1;
      end else if (strobe_q) begin
        if (w_is_digit) begin
          if (discard_q) begin
            // Message already spoiled; wait for its terminator silently
          end else if (cnt_q == C_CNT_FULL) begin
            err_q     <= 1'b1;
            discard_q <= 1'b1;
          end else begin
            acc_q <= {acc_q[C_VAL_W-5:0], w_nibble};
            cnt_q <= cnt_q + C_NUM_W'(1);
          end
        end else if (w_is_term) begin
          if (discard_q) begin
            acc_q     <= '0;
            cnt_q     <= '0;
            discard_q <= 1'b0;
          end else if (cnt_q == '0) begin
            // Empty message (e.g. LF of a CR LF pair): nothing to do
          end else if (finish_q) begin
            // Previous message still owned downstream, even if released this cycle
            err_q <= 1'b1;
            acc_q <= '0;
            cnt_q <= '0;
          end else begin
            value_q  <= acc_q;
            number_q <= cnt_q;
            finish_q <= 1'b1;
            acc_q    <= '0;
            cnt_q    <= '0;
          end
        end else begin
          err_q     <= 1'b1;
          discard_q <= 1'b1;
        end
      end
    end
  end

  assign OUT_value  = value_q;
  assign OUT_number = number_q;
  assign OUT_finish = finish_q;
  assign OUT_err    = err_q;

endmodule
`default_nettype wire

// File: tb/tb_serial_input.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
// Module      : tb_serial_input
// Description : Directed bench for serial_input: table of messages with
//               hand-computed results plus multi-cycle corner sequences.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_serial_input;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        rx = 1'b1;
  logic        shake = 1'b0;
  logic [63:0] value;
  logic [4:0]  number;
  logic        finish;
  logic        err;

  int total = 0;
  int bad   = 0;
  int errs  = 0;

  always #5 clk = ~clk;

  serial_input #(.OVERSAMPLE(16), .MAX_DIGITS(16)) dut (
    .IN_clk        (clk),
    .IN_rst_n      (rst_n),
    .IN_rx         (rx),
    .IN_shake_hand (shake),
    .OUT_value     (value),
    .OUT_number    (number),
    .OUT_finish    (finish),
    .OUT_err       (err)
  );

  // Count every error pulse
  always @(negedge clk) if (err === 1'b1) errs++;

  typedef struct {
    string       msg;
    logic [63:0] val;
    int          num;
    bit          fin;
    int          nerr;
  } vec_t;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // One 8N1 frame, 16 clocks per bit; caller is at a falling edge
  task automatic send_byte(input logic [7:0] b, input bit good_stop);
    rx = 1'b0;
    repeat (16) @(negedge clk);
    for (int i = 0; i < 8; i++) begin
      rx = b[i];
      repeat (16) @(negedge clk);
    end
    rx = good_stop;
    repeat (16) @(negedge clk);
    if (!good_stop) begin
      rx = 1'b1;
      repeat (32) @(negedge clk);
    end
  endtask

  task automatic send_str(input string s);
    for (int i = 0; i < s.len(); i++) send_byte(s[i], 1'b1);
  endtask

  task automatic handshake();
    shake = 1'b1;
    @(negedge clk);
    shake = 1'b0;
  endtask

  vec_t vecs[8];

  initial begin
    int          e0;
    bit          stable;
    logic [63:0] v0;

    vecs[0] = '{"ffffffffffffffff\n", 64'hFFFF_FFFF_FFFF_FFFF, 16, 1'b1, 0};
    vecs[1] = '{"0\r",                64'h0,                   1,  1'b1, 0};
    vecs[2] = '{{"5555555555", "5555555", "\r"}, 64'h0,        1,  1'b0, 1};
    vecs[3] = '{"7\r",                64'h7,                   1,  1'b1, 0};
    vecs[4] = '{"\r\n",               64'h7,                   1,  1'b0, 0};
    vecs[5] = '{"aB9\r\n",            64'hAB9,                 3,  1'b1, 0};
    vecs[6] = '{"g1\r",               64'hAB9,                 3,  1'b0, 1};
    vecs[7] = '{"Ff\n",               64'hFF,                  2,  1'b1, 0};

    // Reset values
    repeat (3) @(negedge clk);
    chk("rst_value",  value,  64'h0);
    chk("rst_number", {59'b0, number}, 64'h0);
    chk("rst_finish", {63'b0, finish}, 64'h0);
    chk("rst_err",    {63'b0, err},    64'h0);
    rst_n = 1'b1;
    repeat (20) @(negedge clk);

    // "1A3F\r" with exact finish timing relative to the CR start bit
    e0 = errs;
    send_str("1A3F");
    fork
      send_byte(8'h0D, 1'b1);
      begin
        repeat (155) @(negedge clk);
        chk("fin_not_yet", {63'b0, finish}, 64'h0);
        @(negedge clk);
        chk("fin_rise", {63'b0, finish}, 64'h1);
      end
    join
    chk("v1a3f_value",  value, 64'h1A3F);
    chk("v1a3f_number", {59'b0, number}, 64'd4);
    stable = 1'b1;
    for (int i = 0; i < 1000; i++) begin
      @(negedge clk);
      if (finish !== 1'b1 || value !== 64'h1A3F || number !== 5'd4) stable = 1'b0;
    end
    chk("hold_stable", {63'b0, stable}, 64'h1);
    handshake();
    chk("hs_drop",  {63'b0, finish}, 64'h0);
    chk("hs_value", value, 64'h1A3F);
    chk("v1a3f_errs", errs - e0, 64'd0);

    // Table of messages
    for (int k = 0; k < 8; k++) begin
      e0 = errs;
      send_str(vecs[k].msg);
      repeat (4) @(negedge clk);
      chk($sformatf("vec%0d_finish", k), {63'b0, finish}, {63'b0, vecs[k].fin});
      chk($sformatf("vec%0d_value", k),  value, vecs[k].val);
      chk($sformatf("vec%0d_number", k), {59'b0, number}, 64'(vecs[k].num));
      chk($sformatf("vec%0d_errs", k),   64'(errs - e0), 64'(vecs[k].nerr));
      if (vecs[k].fin) begin
        handshake();
        chk($sformatf("vec%0d_release", k), {63'b0, finish}, 64'h0);
      end
    end

    // Drop error: second message while first still owned
    e0 = errs;
    send_str("12\r");
    send_str("34\r");
    repeat (4) @(negedge clk);
    chk("drop_errs",   64'(errs - e0), 64'd1);
    chk("drop_finish", {63'b0, finish}, 64'h1);
    chk("drop_value",  value, 64'h12);
    // Terminator strobe coincides with the handshake sample
    send_str("5");
    fork
      send_byte(8'h0D, 1'b1);
      begin
        repeat (155) @(negedge clk);
        shake = 1'b1;
        @(negedge clk);
        shake = 1'b0;
      end
    join
    repeat (4) @(negedge clk);
    chk("simul_errs",   64'(errs - e0), 64'd2);
    chk("simul_finish", {63'b0, finish}, 64'h0);
    chk("simul_value",  value, 64'h12);
    send_str("56\r");
    repeat (4) @(negedge clk);
    chk("after_drop_value", value, 64'h56);
    handshake();

    // Glitch then framing error inside "12\r"
    e0 = errs;
    rx = 1'b0;
    repeat (4) @(negedge clk);
    rx = 1'b1;
    repeat (40) @(negedge clk);
    chk("glitch_errs", 64'(errs - e0), 64'd0);
    send_byte("1", 1'b1);
    send_byte("2", 1'b0);
    send_byte(8'h0D, 1'b1);
    repeat (4) @(negedge clk);
    chk("frame_errs",   64'(errs - e0), 64'd1);
    chk("frame_finish", {63'b0, finish}, 64'h0);
    send_str("9\r");
    repeat (4) @(negedge clk);
    chk("after_frame_value",  value, 64'h9);
    chk("after_frame_number", {59'b0, number}, 64'd1);
    handshake();

    // Reset during the data bits of 'B' in "AB\r"
    e0 = errs;
    send_byte("A", 1'b1);
    v0 = 64'h42;
    rx = 1'b0;
    repeat (16) @(negedge clk);
    for (int i = 0; i < 3; i++) begin
      rx = v0[i];
      repeat (16) @(negedge clk);
    end
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    chk("midrst_value",  value, 64'h0);
    chk("midrst_number", {59'b0, number}, 64'h0);
    chk("midrst_finish", {63'b0, finish}, 64'h0);
    rx = 1'b1;
    repeat (5) @(negedge clk);
    rst_n = 1'b1;
    repeat (40) @(negedge clk);
    chk("midrst_quiet", {finish, 31'b0, 32'(errs - e0)}, 64'h0);
    send_str("C\r");
    repeat (4) @(negedge clk);
    chk("after_rst_value",  value, 64'hC);
    chk("after_rst_number", {59'b0, number}, 64'd1);
    chk("after_rst_finish", {63'b0, finish}, 64'h1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire
